// File: rtl/bcd_pkg.sv
// Shared constants and state type for the binary-to-BCD converter.
package bcd_pkg;

    localparam int          NUM_DIGITS  = 4;
    localparam logic [3:0]  BCD_BLANK   = 4'hF;
    localparam int          MAX_DISPLAY = 9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Pre-shift correction so the following left shift carries correctly into the next digit.
    always_comb begin
        digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter feeding the 4-digit 7-segment driver.
// Fixed latency of BIN_W+1 edges from acceptance; result held between conversions.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W    = 14,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             load,
    output logic             ready,
    output logic [15:0]      digits_bcd,
    output logic             bcd_valid,
    output logic             overflow
);

    localparam logic [15:0] ZERO_CODE = BLANK_LZ ? 16'hFFF0 : 16'h0000;

    state_t             state_q,   state_d;
    logic [BIN_W-1:0]   shreg_q,   shreg_d;
    logic [15:0]        scratch_q, scratch_d;
    logic [4:0]         cnt_q,     cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [15:0]        digits_q,  digits_d;
    logic               ovf_q,     ovf_d;
    logic               valid_q,   valid_d;

    logic [15:0]        scratch_adj;
    logic [15:0]        blanked;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (scratch_q[g*4 +: 4]),
            .digit_out (scratch_adj[g*4 +: 4])
        );
    end

    // Leading-zero blanking of the finished conversion; digit 0 always shown.
    always_comb begin
        blanked = scratch_q;
        if (BLANK_LZ) begin
            if (scratch_q[15:12] == 4'd0) blanked[15:12] = BCD_BLANK;
            if (scratch_q[15:8]  == 8'd0) blanked[11:8]  = BCD_BLANK;
            if (scratch_q[15:4]  == 12'd0) blanked[7:4]  = BCD_BLANK;
        end
    end

    // Next-state and datapath: capture in IDLE, one dabble step per SHIFT cycle, publish in DONE.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d    = bin_in;
                    scratch_d  = '0;
                    cnt_d      = 5'(BIN_W);
                    ovf_pend_d = (32'(bin_in) > 32'(MAX_DISPLAY));
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // Carry out of digit 3 is dropped; values that large take the overflow path.
                scratch_d = 16'({scratch_adj, shreg_q[BIN_W-1]});
                shreg_d   = shreg_q << 1;
                cnt_d     = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_d = 1'b1;
                if (ovf_pend_q) begin
                    digits_d = '1;
                    ovf_d    = 1'b1;
                end else begin
                    digits_d = blanked;
                    ovf_d    = 1'b0;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            digits_q   <= ZERO_CODE;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            digits_q   <= digits_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign digits_bcd = digits_q;
    assign bcd_valid  = valid_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: two instances (blanking on/off) driven in parallel,
// checked against a decimal reference model.
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 14;
    localparam int LAT   = BIN_W + 1;

    logic              clk;
    logic              rst;
    logic [BIN_W-1:0]  bin_in;
    logic              load;
    logic              ready_a,  ready_b;
    logic [15:0]       digits_a, digits_b;
    logic              valid_a,  valid_b;
    logic              ovf_a,    ovf_b;

    int checks;
    int failures;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .BLANK_LZ(1'b1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .bin_in     (bin_in),
        .load       (load),
        .ready      (ready_a),
        .digits_bcd (digits_a),
        .bcd_valid  (valid_a),
        .overflow   (ovf_a)
    );

    bin_to_bcd_seq #(.BIN_W(BIN_W), .BLANK_LZ(1'b0)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .bin_in     (bin_in),
        .load       (load),
        .ready      (ready_b),
        .digits_bcd (digits_b),
        .bcd_valid  (valid_b),
        .overflow   (ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal digits by division; leading zeros above digit 0 become F when blanking.
    function automatic logic [15:0] model(input int v, input bit blank);
        logic [15:0] r;
        bit          lead;
        int          d;
        if (v > 9999) return 16'hFFFF;
        r    = '0;
        lead = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            d = (v / (10 ** i)) % 10;
            if (blank && lead && d == 0 && i != 0) begin
                r[i*4 +: 4] = 4'hF;
            end else begin
                r[i*4 +: 4] = 4'(d);
                lead = 1'b0;
            end
        end
        return r;
    endfunction

    // One full conversion; optionally pulses load with another value across edge poke_edge.
    task automatic convert(input int v, input int poke_edge, input int poke_val);
        @(negedge clk);
        bin_in = BIN_W'(v);
        load   = 1'b1;
        check("ready_a_idle", ready_a, 1);
        check("ready_b_idle", ready_b, 1);
        @(posedge clk); #1;
        load = 1'b0;
        for (int e = 1; e <= LAT; e++) begin
            if (poke_edge > 0 && e == poke_edge) begin
                load   = 1'b1;
                bin_in = BIN_W'(poke_val);
            end
            @(posedge clk); #1;
            load = 1'b0;
            check("valid_a_timing", valid_a, (e == LAT));
            check("valid_b_timing", valid_b, (e == LAT));
            check("ready_a_timing", ready_a, (e == LAT));
        end
        check("digits_a", digits_a, model(v, 1'b1));
        check("digits_b", digits_b, model(v, 1'b0));
        check("ovf_a", ovf_a, (v > 9999));
        check("ovf_b", ovf_b, (v > 9999));
        @(posedge clk); #1;
        check("valid_a_pulse_end", valid_a, 0);
        check("digits_a_hold", digits_a, model(v, 1'b1));
        check("ready_a_after", ready_a, 1);
    endtask

    initial begin
        int v;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        load     = 1'b0;
        bin_in   = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_digits_a", digits_a, 16'hFFF0);
        check("rst_digits_b", digits_b, 16'h0000);
        check("rst_ready", ready_a, 1);
        check("rst_valid", valid_a, 0);
        check("rst_ovf", ovf_a, 0);
        rst = 1'b0;

        convert(1234, 0, 0);
        convert(0, 0, 0);
        convert(7, 0, 0);
        convert(9999, 0, 0);
        convert(10000, 0, 0);
        convert(42, 0, 0);
        convert(500, 5, 321);
        convert(16383, 0, 0);
        convert(10, 0, 0);
        convert(100, 0, 0);

        for (int n = 0; n < 24; n++) begin
            v = (n % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 16383));
            convert(v, 0, 0);
        end

        // Reset in the middle of converting 8888.
        convert(1234, 0, 0);
        @(negedge clk);
        bin_in = BIN_W'(8888);
        load   = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", valid_a, 0);
        check("midrst_digits_a", digits_a, 16'hFFF0);
        check("midrst_digits_b", digits_b, 16'h0000);
        check("midrst_ovf", ovf_a, 0);
        check("midrst_ready", ready_a, 1);
        convert(42, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential double-dabble binary-to-BCD converter.
- Sits directly upstream of the time-multiplexed 7-segment driver and produces its 16-bit, 4-digit BCD input bus.
- Accepts an unsigned binary count through a valid/ready handshake and converts it in fixed latency.
- Holds the last result stable between conversions, so the display never shows intermediate values.
- Optionally blanks leading zeros by emitting digit code 4'hF, which the driver renders as blank.

Parameters:
- BIN_W, 14, width of the binary input. Legal range 4..16.
- BLANK_LZ, 1, 1 = replace leading zero digits with 4'hF. Digit 0 is never blanked.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- bin_in  in  BIN_W  unsigned value to convert.
- load  in  1  request valid; sampled only when ready=1.
- ready  out  1  high when state=IDLE (decoded from state register).
- digits_bcd  out  16  digit3 in [15:12] down to digit0 in [3:0]; feeds the display driver.
- bcd_valid  out  1  one-cycle pulse marking a digits_bcd update.
- overflow  out  1  registered with digits_bcd; 1 = last accepted value exceeded 9999.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - state to IDLE; ready=1.
  - bcd_valid=0, overflow=0.
  - digits_bcd to the encoding of 0: 16'hFFF0 if BLANK_LZ=1, else 16'h0000.
  - Scratch registers cleared.
- Reset mid-conversion aborts the conversion and produces no bcd_valid pulse.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - If load=1, the value is accepted on edge E0.
  - On acceptance, bin_in is captured into the shift register, the 16-bit BCD scratch is cleared, the iteration counter is set to BIN_W, and state goes to SHIFT.
- SHIFT, one iteration per cycle:
  - Add 3 to every scratch digit that is >= 5.
  - Then shift {scratch, shift register} left by 1.
  - Decrement the counter. After the BIN_W-th iteration (edge E_BIN_W), state goes to DONE.
- DONE, on edge E_(BIN_W+1):
  - Update digits_bcd and overflow, set bcd_valid=1, and return to IDLE.
  - bcd_valid clears on the next edge unless another DONE occurs.
- Latency:
  - digits_bcd changes exactly BIN_W+1 edges after the accepting edge (15 edges at default BIN_W).
  - The next load can be accepted at E_(BIN_W+2), giving a throughput of one value per BIN_W+2 cycles.
- Overflow:
  - Captured at E0 as (bin_in > 9999).
  - If set, DONE writes digits_bcd=16'hFFFF and overflow=1. Latency stays fixed.
  - Otherwise DONE writes overflow=0.
- Leading-zero blanking (BLANK_LZ=1) is applied at DONE to the converted digits:
  - digit3 is blanked if it is 0.
  - digit2 is blanked if digits 3 and 2 are both 0.
  - digit1 is blanked if digits 3, 2 and 1 are all 0.
- Scratch width: the BCD scratch keeps 16 bits. For BIN_W=16, carries out of digit3 are discarded, which is harmless because the overflow path substitutes the result.
- load=1 while not in IDLE is ignored: no capture and no effect on the ongoing conversion.
- load held high continuously starts a new conversion every BIN_W+2 cycles.
- digits_bcd and overflow change only at DONE or reset and are never glitch-updated.

Decomposition:
- Shared package bcd_pkg holds:
  - NUM_DIGITS=4, BCD_BLANK=4'hF, MAX_DISPLAY=9999.
  - The state enum {IDLE, SHIFT, DONE}.
- One natural combinational sub-module, bcd_digit_adj: the 4-bit add-3-if->=5 cell, instantiated 4 times.
- Blanking logic stays inline.

Test Plan:
- Reset with BLANK_LZ=1 -> digits_bcd=16'hFFF0, ready=1, bcd_valid=0, overflow=0.
- load with bin_in=1234 at E0 -> digits_bcd=16'h1234 and bcd_valid=1 for exactly one cycle after E15; ready=0 during E1..E15.
- bin_in=0, then 7, then 9999 -> 16'hFFF0, 16'hFFF7, 16'h9999. With BLANK_LZ=0 -> 16'h0000, 16'h0007.
- bin_in=10000 -> digits_bcd=16'hFFFF, overflow=1. A following bin_in=42 -> 16'hFF42, overflow=0.
- Accept bin_in=500, then pulse load with bin_in=321 at E5 -> result 16'hF500; the second request is not captured.
- rst=1 at E8 of a conversion of 8888 -> no bcd_valid pulse, digits_bcd=16'hFFF0; a new load is accepted on the first edge after rst deasserts.
